// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store stage.
// Data accesses win arbitration unless fetch has been starved for STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  output logic                    if_stall,
  input  logic                    dm_load,
  input  logic                    dm_store,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_mask,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    dm_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, F_REQ, F_WAIT, D_REQ, D_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q;
  logic       discard_q;
  logic       store_q;
  logic       if_valid_q;
  logic       dm_valid_q;
  logic       dm_any;
  logic       can_sample;
  logic       fetch_win;
  logic       data_win;

  assign dm_any     = dm_load | dm_store;
  assign if_valid   = if_valid_q & ~flush;
  assign dm_valid   = dm_valid_q;
  assign if_stall   = if_req & ~if_valid;
  assign dm_stall   = dm_any & ~dm_valid;

  // A stage that is consuming a valid pulse still shows its request; don't serve it twice.
  assign can_sample = ~if_valid & ~dm_valid;
  assign fetch_win  = can_sample & if_req & ~flush & ((starve_q == STARVE_MAX) | ~dm_any);
  assign data_win   = can_sample & dm_any & ~fetch_win;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_win)     state_d = F_REQ;
        else if (data_win) state_d = D_REQ;
      end
      F_REQ: begin
        if (mem_gnt)    state_d = F_WAIT;
        else if (flush) state_d = IDLE;
      end
      F_WAIT:  if (mem_rvalid) state_d = IDLE;
      D_REQ:   if (mem_gnt)    state_d = D_WAIT;
      D_WAIT:  if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      F_REQ: mem_req = 1'b1;
      D_REQ: begin
        mem_req = 1'b1;
        mem_we  = store_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= '0;
      discard_q  <= 1'b0;
      store_q    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_win) begin
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_mask  <= '1;
            store_q   <= 1'b0;
            starve_q  <= '0;
          end else if (data_win) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_mask  <= dm_mask;
            store_q   <= dm_store;
            if (if_req && (starve_q != STARVE_MAX)) starve_q <= starve_q + 4'd1;
          end
        end
        F_REQ: if (mem_gnt && flush) discard_q <= 1'b1;
        F_WAIT: begin
          if (mem_rvalid) begin
            // A redirect arriving with the response still kills it.
            if (!discard_q && !flush) begin
              if_rdata   <= mem_rdata;
              if_valid_q <= 1'b1;
            end
            discard_q <= 1'b0;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        D_WAIT: begin
          if (mem_rvalid) begin
            dm_valid_q <= 1'b1;
            if (!store_q) dm_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory interface between the instruction-fetch stage and the memory (load/store) stage of the 5-stage RV32I pipeline.
- Sequences each transaction through a req/gnt/rvalid handshake and returns read data.
- Generates per-stage stall signals that the hazard logic ORs into the pipeline stall/flush network.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced; must be 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_WIDTH  fetch PC.
- flush  in  1  branch/jump redirect; kills an outstanding fetch.
- if_rdata  out  DATA_WIDTH  fetched instruction.
- if_valid  out  1  one-cycle fetch-complete pulse.
- if_stall  out  1  fetch stage must hold.
- dm_load  in  1  load request.
- dm_store  in  1  store request.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_mask  in  DATA_WIDTH/8  byte enables.
- dm_rdata  out  DATA_WIDTH  load data.
- dm_valid  out  1  one-cycle load/store-complete pulse.
- dm_stall  out  1  memory stage must hold.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_mask  out  DATA_WIDTH/8  byte enables.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  read data / write ack valid.
- mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Clock/reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at an edge), regardless of in-flight transaction:
  - state to IDLE; starve counter and discard flag to 0.
  - All mem_* outputs to 0.
  - if_valid, dm_valid to 0; if_rdata, dm_rdata to 0.
  - Any later mem_gnt or mem_rvalid belonging to the aborted transaction is ignored in IDLE.
- FSM states: IDLE, F_REQ, F_WAIT, D_REQ, D_WAIT.
- IDLE arbitration:
  - Requests are sampled only when if_valid and dm_valid are both low, so a stage advancing on a valid pulse is not re-served.
  - A data request is dm_load|dm_store; if both are high, the access is a store.
  - Fetch wins if starve==STARVE_LIMIT and if_req is high; otherwise data wins over fetch.
  - The winner's address, wdata and mask are captured into registers at the decision edge; state moves to F_REQ or D_REQ.
  - A fetch is not started if flush is high that cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each data grant decision while if_req is high.
  - Clears on every fetch grant decision.
- *_REQ states:
  - mem_req=1 with the registered address, wdata and mask.
  - Fetch: mem_mask is all ones and mem_we=0. Data: mem_mask=dm_mask and mem_we=1 only for a store.
  - Remain in the state until mem_gnt, then go to *_WAIT; mem_req drops the cycle after gnt.
- *_WAIT states: mem_req=0. On mem_rvalid, register mem_rdata into if_rdata or dm_rdata (stores leave dm_rdata unchanged), pulse the matching valid the next cycle, and return to IDLE.
- Latency: minimum 3 cycles from request sampled in IDLE to valid pulse (decision, REQ with same-cycle gnt, WAIT with same-cycle rvalid, then valid). Every extra gnt or rvalid wait cycle adds 1.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - dm_stall = (dm_load|dm_store) & ~dm_valid.
- Flush:
  - In F_REQ without same-cycle mem_gnt: abort to IDLE; mem_req drops next cycle.
  - In F_REQ with mem_gnt, or in F_WAIT: set the discard flag; the transaction completes on the memory side but if_valid is suppressed and if_rdata is not updated. The flag clears on return to IDLE.
  - In the cycle if_valid is high: if_valid is masked to 0.
  - Flush never affects data transactions.
- Spurious responses: mem_gnt outside *_REQ and mem_rvalid outside *_WAIT are ignored.
- Only one transaction is outstanding at any time.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, gnt immediate, rvalid one cycle later with 0x00500093 -> if_valid pulses 3 cycles after request with if_rdata=0x00500093; mem_mask=0xF, mem_we=0.
- Simultaneous requests: if_req and dm_load to 0x2000 in the same cycle -> data served first (mem_addr=0x2000), dm_valid pulses, then the fetch is served; if_stall stays high throughout the data access.
- Starvation: with STARVE_LIMIT=4, dm_store held continuously with new addresses plus if_req held -> exactly 4 data grants, then a fetch grant, then the counter resets.
- Flush in F_WAIT: fetch granted, flush=1 before rvalid with 0xDEADBEEF -> no if_valid and if_rdata unchanged; the next fetch to 0x200 completes normally.
- Store with mask: dm_store, dm_addr=0x3004, dm_wdata=0xA5A5A5A5, dm_mask=0x3, gnt delayed 2 cycles -> mem_req held 3 cycles with stable mem_addr, mem_wdata and mem_mask, mem_we=1; dm_valid pulses after rvalid ack.
- Reset mid-operation: rst_n=0 during D_WAIT, then a stray rvalid arrives after release -> all outputs 0, state IDLE, no dm_valid pulse.
